mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port if_req, input, 1 bit: instruction-fetch word read request, held high until if_done.
REQ-005 The block SHALL have port if_addr, input, 5 bits: fetch byte address.
REQ-006 The block SHALL have port if_rdata, output, 32 bits: fetched word.
REQ-007 The block SHALL have port if_done, output, 1 bit: single-cycle fetch completion pulse.
REQ-008 The block SHALL have port dm_req, input, 1 bit: data access request, held high until dm_done.
REQ-009 The block SHALL have port dm_we, input, 1 bit: 1 = word store, 0 = word load.
REQ-010 The block SHALL have port dm_addr, input, 5 bits: data byte address.
REQ-011 The block SHALL have port dm_wdata, input, 32 bits: store data.
REQ-012 The block SHALL have port dm_rdata, output, 32 bits: loaded word.
REQ-013 The block SHALL have port dm_done, output, 1 bit: single-cycle data completion pulse.
REQ-014 The block SHALL have port mem_addr, output, 5 bits: byte address to the shared 32x8 memory.
REQ-015 The block SHALL have port mem_we, output, 1 bit: byte write enable.
REQ-016 The block SHALL have port mem_wdata, output, 8 bits: byte write data.
REQ-017 The block SHALL have port mem_rdata, input, 8 bits: byte read data, combinational from mem_addr in the same cycle.
REQ-018 The block SHALL have port busy, output, 1 bit: high in the XFER and DONE states.
REQ-019 The block SHALL have port owner, output, 1 bit: current or last grant (0 = IF, 1 = DM).

Function
REQ-020 The FSM SHALL have three states: IDLE, XFER and DONE, with a 2-bit byte counter k.
REQ-021 In IDLE, with any request high at a rising edge, the block SHALL latch the grant, address, we and wdata, and move to XFER with k=0.
REQ-022 Arbitration SHALL be: a single request wins; for simultaneous requests, the port that is not last_owner wins; last_owner SHALL update on each grant.
REQ-023 In XFER, the block SHALL drive mem_addr = (base + k) mod 32, so the address wraps at 5 bits.
REQ-024 Byte order SHALL be big-endian: k=0 maps to word bits [31:24], and k=3 maps to bits [7:0].
REQ-025 For a store, the block SHALL drive mem_we=1 and mem_wdata = the latched wdata byte k in each XFER cycle; mem_we SHALL be 0 in all other cycles and for loads and fetches.
REQ-026 For a load or fetch, the block SHALL capture mem_rdata into byte k of an internal word register at each XFER edge.
REQ-027 After the k=3 cycle, the FSM SHALL go to DONE, then to IDLE on the next edge.
REQ-028 In DONE, the block SHALL pulse the owner's done signal high for exactly one cycle, and the owner's rdata SHALL be valid from that cycle.
REQ-029 For a store, the block SHALL pulse dm_done, and dm_rdata SHALL remain unchanged.
REQ-030 if_rdata and dm_rdata SHALL each hold their value until that port's next read completion.
REQ-031 Latency SHALL be: request sampled in IDLE at cycle 0, XFER in cycles 1-4, done in cycle 5, IDLE in cycle 6; each word takes 6 cycles.
REQ-032 Request inputs SHALL be ignored outside IDLE; a request dropped mid-transfer SHALL NOT abort the transfer, and done SHALL still pulse.
REQ-033 A request still high in IDLE after its done pulse SHALL be treated as a new request.
REQ-034 A losing requester SHALL wait with no starvation: under continuous dual requests, grants SHALL strictly alternate.
REQ-035 mem_addr SHALL equal the latched base in DONE, and 0 in IDLE.

Reset
REQ-036 Reset assertion SHALL immediately force: state IDLE, k=0, last_owner=1, owner=0, all done pulses 0, busy=0, mem_we=0, mem_addr=0, mem_wdata=0, if_rdata=0, dm_rdata=0.
REQ-037 Reset during XFER SHALL abort the transfer with no done pulse; bytes already written SHALL remain in memory.
REQ-038 The first simultaneous request after reset SHALL be granted to IF.

Verification
REQ-039 Fetch test: memory bytes 0..3 = 8C,01,00,04; if_req=1 with if_addr=0 -> busy for cycles 1-5, if_done in cycle 5, if_rdata=8C010004.
REQ-040 Store test: dm_req=1, dm_we=1, dm_addr=8, dm_wdata=DEADBEEF -> mem_we high for 4 cycles at addresses 8,9,10,11 with bytes DE,AD,BE,EF; dm_done in cycle 5.
REQ-041 Wrap test: load at dm_addr=30 with bytes[30,31,0,1] = 11,22,33,44 -> mem_addr sequence 30,31,0,1 and dm_rdata=11223344.
REQ-042 Arbitration test: after reset, if_req and dm_req held high -> grant order IF, DM, IF, DM; each done pulse arrives 6 cycles after the previous one.
REQ-043 Reset test: assert reset during the XFER cycle with k=2 of a store of AABBCCDD to address 4 -> bytes 4,5 = AA,BB, bytes 6,7 unchanged, no dm_done, busy=0 immediately.
REQ-044 Drop test: if_req falls in XFER cycle 2 -> transfer completes and if_done still pulses in cycle 5.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one 32x8 byte-wide memory between an instruction-fetch port and a
// data port. Each 32-bit word moves as four big-endian byte cycles. When both
// ports request at once, the port that did not win last time is granted, so
// neither side can be starved.
module mem_port_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [4:0]  if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [4:0]  dm_addr,
    input  logic [31:0] dm_wdata,
    output logic [31:0] dm_rdata,
    output logic        dm_done,
    output logic [4:0]  mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [1:0]  k;
    logic [1:0]  k_nxt;
    logic        last_owner;
    logic        grant;
    logic        start;
    logic [4:0]  base;
    logic        store;
    logic [31:0] wdata_l;
    logic [31:0] word;
    logic [31:0] word_nxt;

    // Byte idx of a word, big-endian: idx 0 is bits [31:24].
    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    // Replace byte idx of a word, big-endian.
    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        case (idx)
            2'd0:    r[31:24] = b;
            2'd1:    r[23:16] = b;
            2'd2:    r[15:8]  = b;
            default: r[7:0]   = b;
        endcase
        return r;
    endfunction

    // Word register with the byte arriving this cycle merged in.
    assign word_nxt = put_byte(word, k, mem_rdata);

    // Next-state, arbitration and memory-side outputs.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        grant     = 1'b0;
        start     = 1'b0;
        busy      = 1'b0;
        if_done   = 1'b0;
        dm_done   = 1'b0;
        mem_addr  = 5'd0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        case (state)
            IDLE: begin
                if (if_req || dm_req) begin
                    start     = 1'b1;
                    grant     = (if_req && dm_req) ? ~last_owner : dm_req;
                    state_nxt = XFER;
                    k_nxt     = 2'd0;
                end
            end
            XFER: begin
                busy     = 1'b1;
                mem_addr = base + {3'b000, k};
                if (store) begin
                    mem_we    = 1'b1;
                    mem_wdata = get_byte(wdata_l, k);
                end
                k_nxt = k + 2'd1;
                if (k == 2'd3) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                mem_addr  = base;
                if_done   = ~owner;
                dm_done   = owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state: FSM, byte counter and grant history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            k          <= 2'd0;
            owner      <= 1'b0;
            last_owner <= 1'b1;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
            if (start) begin
                owner      <= grant;
                last_owner <= grant;
            end
        end
    end

    // Transaction operands latched at grant; read bytes gathered during XFER.
    always_ff @(posedge clk) begin
        if (start) begin
            base    <= grant ? dm_addr : if_addr;
            store   <= grant & dm_we;
            wdata_l <= dm_wdata;
        end
        if (state == XFER && !store) begin
            word <= word_nxt;
        end
    end

    // Publish the completed read word to its port on the last byte edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata <= 32'd0;
            dm_rdata <= 32'd0;
        end else if (state == XFER && k == 2'd3 && !store) begin
            if (owner) begin
                dm_rdata <= word_nxt;
            end else begin
                if_rdata <= word_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with a 32x8 byte memory model.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [4:0]  if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        dm_req;
    logic        dm_we;
    logic [4:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        owner;

    logic [7:0]  mem [32];
    logic        tb_we;
    logic [4:0]  tb_a;
    logic [7:0]  tb_d;

    int checks;
    int errors;

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata),
        .dm_done   (dm_done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, DUT and bench write ports.
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (tb_we)  mem[tb_a] <= tb_d;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [4:0] a, input logic [7:0] d);
        tb_we = 1'b1;
        tb_a  = a;
        tb_d  = d;
        step();
        tb_we = 1'b0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] st_bytes [4];
        logic [4:0] wrap_addr [4];
        checks   = 0;
        errors   = 0;
        tb_we    = 1'b0;
        tb_a     = 5'd0;
        tb_d     = 8'd0;
        if_req   = 1'b0;
        if_addr  = 5'd0;
        dm_req   = 1'b0;
        dm_we    = 1'b0;
        dm_addr  = 5'd0;
        dm_wdata = 32'd0;
        reset    = 1'b1;
        #1;
        // Reset state
        chk("rst_busy",      {31'd0, busy},    32'd0);
        chk("rst_owner",     {31'd0, owner},   32'd0);
        chk("rst_mem_we",    {31'd0, mem_we},  32'd0);
        chk("rst_mem_addr",  {27'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        chk("rst_if_done",   {31'd0, if_done}, 32'd0);
        chk("rst_dm_done",   {31'd0, dm_done}, 32'd0);
        chk("rst_if_rdata",  if_rdata, 32'd0);
        chk("rst_dm_rdata",  dm_rdata, 32'd0);

        // Preload memory while held in reset
        poke(5'd0, 8'h8C);
        poke(5'd1, 8'h01);
        poke(5'd2, 8'h00);
        poke(5'd3, 8'h04);
        poke(5'd8, 8'h00);
        poke(5'd9, 8'h00);
        poke(5'd10, 8'h00);
        poke(5'd11, 8'h00);
        reset = 1'b0;
        step();

        // Fetch test
        if_req  = 1'b1;
        if_addr = 5'd0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("fetch_busy", {31'd0, busy}, 32'd1);
            chk("fetch_addr", {27'd0, mem_addr}, i);
            chk("fetch_we",   {31'd0, mem_we}, 32'd0);
            chk("fetch_done_early", {31'd0, if_done}, 32'd0);
            step();
        end
        chk("fetch_done",     {31'd0, if_done}, 32'd1);
        chk("fetch_dm_done",  {31'd0, dm_done}, 32'd0);
        chk("fetch_rdata",    if_rdata, 32'h8C010004);
        chk("fetch_done_busy", {31'd0, busy}, 32'd1);
        chk("fetch_done_addr", {27'd0, mem_addr}, 32'd0);
        if_req = 1'b0;
        step();
        chk("fetch_idle_busy", {31'd0, busy}, 32'd0);
        chk("fetch_idle_done", {31'd0, if_done}, 32'd0);

        // Store test
        st_bytes[0] = 8'hDE;
        st_bytes[1] = 8'hAD;
        st_bytes[2] = 8'hBE;
        st_bytes[3] = 8'hEF;
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 5'd8;
        dm_wdata = 32'hDEADBEEF;
        step();
        chk("store_owner", {31'd0, owner}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("store_we",    {31'd0, mem_we}, 32'd1);
            chk("store_addr",  {27'd0, mem_addr}, 32'd8 + i);
            chk("store_wdata", {24'd0, mem_wdata}, {24'd0, st_bytes[i]});
            step();
        end
        chk("store_done",     {31'd0, dm_done}, 32'd1);
        chk("store_done_we",  {31'd0, mem_we}, 32'd0);
        chk("store_done_addr", {27'd0, mem_addr}, 32'd8);
        chk("store_dm_rdata", dm_rdata, 32'd0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        step();
        chk("store_mem8",  {24'd0, mem[8]},  32'h0DE);
        chk("store_mem9",  {24'd0, mem[9]},  32'h0AD);
        chk("store_mem10", {24'd0, mem[10]}, 32'h0BE);
        chk("store_mem11", {24'd0, mem[11]}, 32'h0EF);

        // Wrap test
        poke(5'd30, 8'h11);
        poke(5'd31, 8'h22);
        poke(5'd0,  8'h33);
        poke(5'd1,  8'h44);
        wrap_addr[0] = 5'd30;
        wrap_addr[1] = 5'd31;
        wrap_addr[2] = 5'd0;
        wrap_addr[3] = 5'd1;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 5'd30;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("wrap_addr", {27'd0, mem_addr}, {27'd0, wrap_addr[i]});
            chk("wrap_we",   {31'd0, mem_we}, 32'd0);
            step();
        end
        chk("wrap_done",     {31'd0, dm_done}, 32'd1);
        chk("wrap_rdata",    dm_rdata, 32'h11223344);
        chk("wrap_if_rdata", if_rdata, 32'h8C010004);
        dm_req = 1'b0;
        step();

        // Arbitration test: both requests held high after reset
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step();
        if_req  = 1'b1;
        if_addr = 5'd0;
        dm_req  = 1'b1;
        dm_we   = 1'b0;
        dm_addr = 5'd8;
        for (int c = 1; c <= 24; c++) begin
            step();
            chk("arb_if_done", {31'd0, if_done}, {31'd0, (c == 5 || c == 17)});
            chk("arb_dm_done", {31'd0, dm_done}, {31'd0, (c == 11 || c == 23)});
            if (c == 2)  chk("arb_owner_1", {31'd0, owner}, 32'd0);
            if (c == 8)  chk("arb_owner_2", {31'd0, owner}, 32'd1);
            if (c == 14) chk("arb_owner_3", {31'd0, owner}, 32'd0);
            if (c == 20) chk("arb_owner_4", {31'd0, owner}, 32'd1);
        end
        chk("arb_dm_rdata", dm_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        dm_req = 1'b0;
        step();
        step();

        // Reset during store at k=2
        poke(5'd4, 8'h01);
        poke(5'd5, 8'h02);
        poke(5'd6, 8'h03);
        poke(5'd7, 8'h04);
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 5'd4;
        dm_wdata = 32'hAABBCCDD;
        step();
        step();
        step();
        chk("rstx_k2_addr", {27'd0, mem_addr}, 32'd6);
        reset  = 1'b1;
        dm_req = 1'b0;
        dm_we  = 1'b0;
        #1;
        chk("rstx_busy",     {31'd0, busy},    32'd0);
        chk("rstx_mem_we",   {31'd0, mem_we},  32'd0);
        chk("rstx_dm_done",  {31'd0, dm_done}, 32'd0);
        chk("rstx_mem_addr", {27'd0, mem_addr}, 32'd0);
        chk("rstx_dm_rdata", dm_rdata, 32'd0);
        step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            chk("rstx_no_done", {31'd0, dm_done}, 32'd0);
        end
        chk("rstx_mem4", {24'd0, mem[4]}, 32'h0AA);
        chk("rstx_mem5", {24'd0, mem[5]}, 32'h0BB);
        chk("rstx_mem6", {24'd0, mem[6]}, 32'h003);
        chk("rstx_mem7", {24'd0, mem[7]}, 32'h004);

        // Drop test: if_req falls in XFER cycle 2
        if_req  = 1'b1;
        if_addr = 5'd8;
        step();
        step();
        if_req = 1'b0;
        chk("drop_busy", {31'd0, busy}, 32'd1);
        step();
        step();
        chk("drop_not_yet", {31'd0, if_done}, 32'd0);
        step();
        chk("drop_done",  {31'd0, if_done}, 32'd1);
        chk("drop_rdata", if_rdata, 32'hDEADBEEF);
        step();
        chk("drop_idle", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
